// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin request arbiter.
// No logic of its own; the FSM state encoding lives here so the bench and RTL agree on names.
// No flow control involved.
package arb_pkg;

   // Supported requester count range
   localparam int N_MIN = 1;
   localparam int N_MAX = 16;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_t;

   // Index width for n requesters, never narrower than one bit
   function automatic int idw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping modulo N.
// Purely combinational, zero latency.
// No flow control; o_valid is low when no request is set.
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   i_req_s,
   input  logic [IDW-1:0] i_ptr,
   output logic           o_valid,
   output logic [IDW-1:0] o_index
);

   localparam int SW = IDW + 1;

   logic [N-1:0]  w_rot;
   logic [SW-1:0] w_off;
   logic [SW-1:0] w_sum;

   // Rotate so that bit 0 of w_rot corresponds to the requester at ptr
   assign w_rot = N'({i_req_s, i_req_s} >> i_ptr);

   // Lowest set bit of the rotated vector, then map the offset back to an absolute index
   always_comb begin
      o_valid = 1'b0;
      w_off   = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            o_valid = 1'b1;
            w_off   = SW'(j);
         end
      end
      w_sum = {1'b0, i_ptr} + w_off;
      if (w_sum >= SW'(N)) begin
         w_sum = w_sum - SW'(N);
      end
      o_index = w_sum[IDW-1:0];
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for 4-phase requesters with optional input synchronizers and hold timeout.
// Latency: req rise to ack rise is SYNC_STAGES+1 edges when idle; same lag on release.
// No backpressure: ack is held while the winner keeps req high; one dead cycle separates grants.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2,
   parameter int MAX_HOLD    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req,
   output logic [N-1:0]      ack,
   output logic [idw(N)-1:0] grant_id,
   output logic              busy,
   output logic              timeout,
   input  logic              clr_timeout
);

   localparam int IDW = idw(N);
   localparam int HW  = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

   logic [N-1:0]   w_req_s;
   logic           w_pick_vld;
   logic [IDW-1:0] w_pick_idx;
   logic [IDW-1:0] w_ptr_nxt;
   logic [HW-1:0]  w_hold_nxt;
   logic           w_to_set;

   arb_state_t     r_state;
   logic [N-1:0]   r_ack;
   logic [IDW-1:0] r_grant_id;
   logic [IDW-1:0] r_ptr;
   logic [HW-1:0]  r_hold;
   logic           r_busy;
   logic           r_timeout;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_req_s = req;
      end else begin : g_sync
         logic [N-1:0] r_sync [SYNC_STAGES];

         // Plain flop chain per request bit; nothing may sit between stages
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int s = 0; s < SYNC_STAGES; s++) begin
                  r_sync[s] <= '0;
               end
            end else begin
               r_sync[0] <= req;
               for (int s = 1; s < SYNC_STAGES; s++) begin
                  r_sync[s] <= r_sync[s-1];
               end
            end
         end

         assign w_req_s = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .i_req_s (w_req_s),
      .i_ptr   (r_ptr),
      .o_valid (w_pick_vld),
      .o_index (w_pick_idx)
   );

   // Next pointer after the current winner, wrapping N-1 back to 0
   assign w_ptr_nxt = (r_grant_id == IDW'(N - 1)) ? '0 : r_grant_id + 1'b1;

   // Saturating hold counter; timeout fires only on the cycle the limit is first reached
   assign w_hold_nxt = (r_hold == HOLD_LIM) ? r_hold : r_hold + 1'b1;
   assign w_to_set   = (MAX_HOLD != 0) && (r_state == ST_GRANT) &&
                       (r_hold != HOLD_LIM) && (w_hold_nxt == HOLD_LIM);

   // Arbitration FSM with registered ack/grant_id/busy/timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_ack      <= '0;
         r_grant_id <= '0;
         r_ptr      <= '0;
         r_hold     <= '0;
         r_busy     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pick_vld) begin
                  r_ack      <= N'(1) << w_pick_idx;
                  r_grant_id <= w_pick_idx;
                  r_hold     <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               r_hold <= w_hold_nxt;
               // Only the winner's own request matters while granted
               if ((w_req_s & r_ack) == '0) begin
                  r_ack   <= '0;
                  r_ptr   <= w_ptr_nxt;
                  r_state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_ack   <= '0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase

         // Sticky flag; a set in the same cycle beats a clear
         if (w_to_set) begin
            r_timeout <= 1'b1;
         end else if (clr_timeout) begin
            r_timeout <= 1'b0;
         end
      end
   end

   assign ack      = r_ack;
   assign grant_id = r_grant_id;
   assign busy     = r_busy;
   assign timeout  = r_timeout;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios plus random traffic against a behavioural model.
// Model tracks requests seen through a delay queue and picks winners by modular search.
// Inputs change 1ns after each rising edge; outputs are checked at the same point.
module tb_rr_arbiter;

   localparam int N   = 4;
   localparam int SS  = 2;
   localparam int MH  = 8;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           clr_timeout = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N-1:0]   ack;
   logic [IDW-1:0] grant_id;
   logic           busy;
   logic           timeout;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int m_pipe[$];
   int m_phase;   // 0 idle, 1 granted, 2 dead cycle
   int m_ptr;
   int m_win;
   int m_gid;
   int m_gcyc;
   int m_ack;
   bit m_to;

   rr_arbiter #(
      .N           (N),
      .SYNC_STAGES (SS),
      .MAX_HOLD    (MH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .ack         (ack),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout     (timeout),
      .clr_timeout (clr_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit, %0d compared", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pipe.delete();
      for (int i = 0; i < SS; i++) m_pipe.push_back(0);
      m_phase = 0;
      m_ptr   = 0;
      m_win   = 0;
      m_gid   = 0;
      m_gcyc  = 0;
      m_ack   = 0;
      m_to    = 1'b0;
   endtask

   // One clock edge of the reference: r and clr are the inputs present at the edge
   task automatic model_edge(input int r, input bit clr);
      int rs;
      bit set_to;
      bit found;
      rs     = (SS == 0) ? r : m_pipe[0];
      set_to = 1'b0;
      found  = 1'b0;
      case (m_phase)
         0: begin
            for (int i = 0; i < N; i++) begin
               int c;
               c = (m_ptr + i) % N;
               if (!found && ((rs >> c) & 1) == 1) begin
                  found   = 1'b1;
                  m_win   = c;
                  m_gid   = c;
                  m_ack   = 1 << c;
                  m_gcyc  = 0;
                  m_phase = 1;
               end
            end
         end
         1: begin
            if (m_gcyc < MH) begin
               m_gcyc++;
               if (m_gcyc == MH) set_to = 1'b1;
            end
            if (((rs >> m_win) & 1) == 0) begin
               m_ack   = 0;
               m_ptr   = (m_win + 1) % N;
               m_phase = 2;
            end
         end
         default: m_phase = 0;
      endcase
      if (set_to) m_to = 1'b1;
      else if (clr) m_to = 1'b0;
      if (SS > 0) begin
         void'(m_pipe.pop_front());
         m_pipe.push_back(r);
      end
   endtask

   task automatic check_outputs();
      check("ack", 32'(ack), 32'(m_ack));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("timeout", 32'(timeout), 32'(m_to));
      check("onehot_ack", 32'($onehot0(ack)), 32'd1);
   endtask

   task automatic step();
      int r;
      bit c;
      r = int'(req);
      c = clr_timeout;
      @(posedge clk);
      if (rst) model_reset();
      else model_edge(r, c);
      #1;
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Called 1ns after an edge: assert reset mid-cycle, hold across one edge, release mid-cycle
   task automatic do_reset();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_outputs();
      step();
      #2;
      rst = 1'b0;
   endtask

   task automatic wait_mask(input logic [N-1:0] mask, input string tag);
      int k;
      k = 0;
      while ((ack & mask) == '0 && k < 40) begin
         step();
         k++;
      end
      check(tag, 32'((ack & mask) != '0), 32'd1);
   endtask

   task automatic wait_ack_low(input string tag);
      int k;
      k = 0;
      while (ack != '0 && k < 40) begin
         step();
         k++;
      end
      check(tag, 32'(ack), 32'd0);
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 40) begin
         step();
         k++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      int exp_order[5];
      int b;
      bit seen3;

      exp_order = '{0, 1, 2, 3, 0};

      // Power-on reset
      rst = 1'b1;
      model_reset();
      #1;
      check_outputs();
      check("reset_ack", 32'(ack), 32'd0);
      #11;
      rst = 1'b0;

      // Single request: ack after SYNC+1 edges, release after the same lag
      req = 4'b0001;
      run(2);
      check("single_early", 32'(ack), 32'd0);
      step();
      check("single_ack", 32'(ack), 32'b0001);
      check("single_busy", 32'(busy), 32'd1);
      check("single_gid", 32'(grant_id), 32'd0);
      req = 4'b0000;
      run(SS);
      check("single_hold", 32'(ack), 32'b0001);
      step();
      check("single_drop", 32'(ack), 32'd0);
      check("single_release_busy", 32'(busy), 32'd1);
      step();
      check("single_idle", 32'(busy), 32'd0);

      // Contention: everyone requests, each winner releases after two ack cycles
      do_reset();
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_mask(4'b1111, "contention_wait");
         check("contention_order", 32'(grant_id), 32'(exp_order[g]));
         step();
         b = int'(grant_id);
         req[b] = 1'b0;
         wait_ack_low("contention_release");
         req[b] = 1'b1;
      end
      req = 4'b0000;
      wait_idle("contention_idle");

      // Pointer wrap: leave ptr at 3, then requesters 3 and 0 compete
      do_reset();
      req = 4'b0100;
      wait_mask(4'b0100, "wrap_setup");
      req = 4'b0000;
      wait_idle("wrap_setup_idle");
      req = 4'b1001;
      wait_mask(4'b1001, "wrap_first");
      check("wrap_first_gid", 32'(grant_id), 32'd3);
      req[3] = 1'b0;
      wait_mask(4'b0001, "wrap_second");
      check("wrap_second_gid", 32'(grant_id), 32'd0);
      req = 4'b0000;
      wait_idle("wrap_idle");

      // Timeout: long hold raises the flag without revoking the grant
      do_reset();
      req = 4'b0100;
      wait_mask(4'b0100, "to_grant");
      run(MH - 1);
      check("to_not_yet", 32'(timeout), 32'd0);
      step();
      check("to_set", 32'(timeout), 32'd1);
      run(4);
      check("to_sticky", 32'(timeout), 32'd1);
      check("to_ack_kept", 32'(ack), 32'b0100);
      clr_timeout = 1'b1;
      step();
      clr_timeout = 1'b0;
      check("to_cleared", 32'(timeout), 32'd0);
      req = 4'b0000;
      wait_idle("to_idle");

      // Reset during a grant drops ack without a clock edge
      do_reset();
      req = 4'b0010;
      wait_mask(4'b0010, "rst_grant");
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_async_ack", 32'(ack), 32'd0);
      check("rst_async_busy", 32'(busy), 32'd0);
      step();
      #2;
      rst = 1'b0;
      run(2);
      check("rst_regrant_early", 32'(ack), 32'd0);
      step();
      check("rst_regrant", 32'(ack), 32'b0010);
      req = 4'b0000;
      wait_idle("rst_idle");

      // Withdrawn request: a one-cycle pulse while busy is never granted
      do_reset();
      req = 4'b0001;
      wait_mask(4'b0001, "wd_grant");
      seen3 = 1'b0;
      req[3] = 1'b1;
      step();
      req[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (ack[3]) seen3 = 1'b1;
      end
      req = 4'b0000;
      for (int i = 0; i < 12; i++) begin
         step();
         if (ack[3]) seen3 = 1'b1;
      end
      check("withdrawn_never_acked", 32'(seen3), 32'd0);

      // Random traffic against the model
      do_reset();
      for (int cyc = 0; cyc < 700; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
               if ($urandom_range(0, 5) == 0) req[i] = 1'b0;
            end else if (!req[i]) begin
               if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
            end else if ($urandom_range(0, 19) == 0) begin
               req[i] = 1'b0;
            end
         end
         clr_timeout = ($urandom_range(0, 9) == 0);
         if (cyc == 350) do_reset();
         step();
      end
      clr_timeout = 1'b0;
      req = '0;
      wait_idle("random_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
